sdp_ram_bw: RTL and testbench
=============================

# sdp_ram_bw

Parametrised simple-dual-port synchronous RAM: one write port with per-byte write enables, one independent read port, selectable read-during-write behaviour and an optional output pipeline register. After reset, a built-in clear sequencer zeroes every location before the ports accept requests. It serves as the general on-chip buffer primitive for datapath blocks that need a known-clean memory at start-up.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- ADDR_WIDTH, 6: address bits; DEPTH = 2**ADDR_WIDTH.
- RDW_MODE, 0: same-address read during write; 0 = old data (read-first), 1 = new data (write-first).
- OUT_REG, 0: 1 adds one output register stage.
- CLEAR_ON_RESET, 1: 1 runs the zeroing sweep after reset; 0 skips it (contents undefined).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NUM_BYTES  byte enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse marking new rd_data.
- busy  out  1  high while in reset or clearing; requests ignored.

## Operation
- FSM states: CLEAR, RUN. Reset forces CLEAR (CLEAR_ON_RESET=1) or RUN (=0), clear pointer = 0.
- CLEAR: each cycle writes all-zero to location ptr, ptr increments; after writing DEPTH-1, next state RUN. busy = 1 throughout.
- rst asserted mid-sweep: sweep restarts at address 0.
- RUN: wr_en writes only lanes with wr_be[i]=1; other lanes keep their contents. wr_en with wr_be=0 is a no-op.
- rd_en samples RAM[rd_addr]; rd_en low leaves rd_data unchanged, rd_valid 0.
- Same-address read and write in one cycle: RDW_MODE 0 returns pre-write word; RDW_MODE 1 returns the merged word (enabled lanes from wr_data, others from old contents). Different addresses do not interact.
- wr_en/rd_en while busy = 1: dropped, no state change, no rd_valid.
- Reset values: rd_data = 0, rd_valid = 0, pipeline stage = 0/invalid, busy = 1 while rst is high (0 after release when CLEAR_ON_RESET=0).
- Memory array is not reset directly; only the sweep initialises it.

## Timing
- Read latency: 1 + OUT_REG cycles from rd_en edge to rd_valid/rd_data.
- Write visible to a read issued on the following cycle in all modes.
- Clear sweep: busy falls exactly DEPTH cycles after the first clock edge with rst low; the first accepted request is on the edge where busy is first sampled 0.
- Full throughput: one read and one write per cycle in RUN.
- rd_valid back-to-back for consecutive rd_en cycles; no bubbles.

## Structure
- Shared package sdp_ram_pkg: RDW_OLD/RDW_NEW constants, FSM state encoding (ST_CLEAR, ST_RUN).
- Sub-module sdp_ram_array: bare byte-enabled storage (registered read, RDW handling) for RAM inference; top holds FSM, clear-write mux, output stage, busy/valid.
- Elaboration check: DATA_WIDTH % BYTE_WIDTH == 0.

## Test plan
- Reset with DEPTH=64: busy high for 64 cycles after rst release; then reading every address returns 0x00000000.
- RUN, write 0xDEADBEEF to addr 5 with wr_be=4'b1111, then wr_be=4'b0101 data 0x11223344 -> read addr 5 returns 0xDE22BE44, rd_valid 1+OUT_REG cycles after rd_en.
- Same-cycle read/write addr 9 (old 0xAAAAAAAA, new 0x55555555, be=1111): RDW_MODE 0 -> 0xAAAAAAAA, RDW_MODE 1 -> 0x55555555.
- Assert rst at sweep cycle 30, release -> busy stays high a further 64 cycles; writes issued while busy have no effect (readback 0).
- Back-to-back rd_en for addresses 0..7 after writing addr value -> 8 consecutive rd_valid pulses with data 0..7, for OUT_REG 0 and 1.
- CLEAR_ON_RESET=0: busy 0 on the first cycle after rst release; write/read addr 63 returns written value.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared constants and FSM encoding for the byte-enabled simple-dual-port RAM.
package sdp_ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/sdp_ram_array.sv
// Bare byte-enabled storage with a registered read port and selectable
// read-during-write behaviour; kept free of control logic so it maps to RAM.
module sdp_ram_array
    import sdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RDW_MODE   = RDW_OLD
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
    input  logic                             rd_en_i,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first forwards only the enabled lanes; the rest come from the old word.
    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
        if (RDW_MODE == RDW_NEW && wr_en_i && wr_addr_i == rd_addr_i) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wr_be_i[b]) begin
                    rd_data_d[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sdp_ram_bw.sv
// Simple-dual-port RAM with per-byte write enables, a post-reset zeroing sweep
// and an optional output register stage.
module sdp_ram_bw
    import sdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned RDW_MODE       = RDW_OLD,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
    input  logic                             rd_en_i,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             rd_valid_o,
    output logic                             busy_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("sdp_ram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    clearing;
    logic                    busy;
    logic                    rd_acc;
    logic                    arr_we;
    logic [ADDR_WIDTH-1:0]   arr_waddr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [NumBytes-1:0]     arr_be;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic                    valid1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign clearing = (state_q == ST_CLEAR);
    // rst_i is folded in so requests are dropped on the reset edge as well.
    assign busy     = rst_i | clearing;
    assign busy_o   = busy;
    assign rd_acc   = rd_en_i & ~busy;

    // The sweep borrows the write port with a full-width zero write.
    assign arr_we    = clearing | (wr_en_i & ~busy);
    assign arr_waddr = clearing ? ptr_q : wr_addr_i;
    assign arr_wdata = clearing ? '0 : wr_data_i;
    assign arr_be    = clearing ? '1 : wr_be_i;

    sdp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RDW_MODE   (RDW_MODE)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (arr_we),
        .wr_addr_i (arr_waddr),
        .wr_data_i (arr_wdata),
        .wr_be_i   (arr_be),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= rd_acc;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] pipe_q;
        logic                  valid2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_q   <= '0;
                valid2_q <= 1'b0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    pipe_q <= arr_rdata;
                end
            end
        end

        assign rd_data_o  = pipe_q;
        assign rd_valid_o = valid2_q;
    end else begin : g_no_out_reg
        assign rd_data_o  = arr_rdata;
        assign rd_valid_o = valid1_q;
    end

endmodule

// File: tb/tb_sdp_ram_bw.sv
// Drives three RAM configurations with one stimulus stream and checks each
// against a word-level behavioural model every cycle.
module tb_sdp_ram_bw;

    localparam int N     = 3;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [31:0] rd_data_w  [N];
    logic        rd_valid_w [N];
    logic        busy_w     [N];

    always #5 clk = ~clk;

    // dut0: read-first, no out reg; dut1: write-first, out reg; dut2: no clear, out reg
    sdp_ram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
                 .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_w[0]), .rd_valid_o(rd_valid_w[0]), .busy_o(busy_w[0]));

    sdp_ram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
                 .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_w[1]), .rd_valid_o(rd_valid_w[1]), .busy_o(busy_w[1]));

    sdp_ram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
                 .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_w[2]), .rd_valid_o(rd_valid_w[2]), .busy_o(busy_w[2]));

    int cfg_rdw [N] = '{0, 1, 0};
    int cfg_lat [N] = '{1, 2, 2};
    int cfg_clr [N] = '{1, 1, 0};

    // Model: contents plus per-lane "known" flags (unswept memory is undefined).
    logic [31:0] mem_m [N][DEPTH];
    logic [3:0]  kn_m  [N][DEPTH];
    int          clr_left [N];
    bit          s1v [N], s1k [N], ev [N], ek [N];
    logic [31:0] s1d [N], ed [N];

    int  vectors = 0;
    int  errors  = 0;
    bit  started = 0;
    int  cyc     = 0;
    bit  collect = 0;
    logic [31:0] col_d [N][16];
    int  col_n [N], col_first [N], col_last [N];

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    task automatic model_step();
        bit          busy, acc_r, acc_w, rk;
        logic [31:0] v;
        logic [3:0]  vk;
        for (int i = 0; i < N; i++) begin
            busy = rst || clr_left[i] > 0;
            if (rst) begin
                clr_left[i] = cfg_clr[i] ? DEPTH : 0;
                s1v[i] = 0; s1d[i] = '0; s1k[i] = 1;
                ev[i]  = 0; ed[i]  = '0; ek[i]  = 1;
                started = 1;
                continue;
            end
            acc_r = rd_en && !busy;
            acc_w = wr_en && !busy;
            v  = mem_m[i][rd_addr];
            vk = kn_m[i][rd_addr];
            if (cfg_rdw[i] == 1 && acc_w && wr_addr == rd_addr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        v[8*b +: 8] = wr_data[8*b +: 8];
                        vk[b] = 1'b1;
                    end
                end
            end
            rk = &vk;
            if (cfg_lat[i] == 1) begin
                ev[i] = acc_r;
                if (acc_r) begin ed[i] = v; ek[i] = rk; end
            end else begin
                ev[i] = s1v[i];
                if (s1v[i]) begin ed[i] = s1d[i]; ek[i] = s1k[i]; end
                s1v[i] = acc_r;
                if (acc_r) begin s1d[i] = v; s1k[i] = rk; end
            end
            if (acc_w) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        mem_m[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                        kn_m[i][wr_addr][b] = 1'b1;
                    end
                end
            end
            if (clr_left[i] > 0) begin
                clr_left[i]--;
                if (clr_left[i] == 0) begin
                    for (int a = 0; a < DEPTH; a++) begin
                        mem_m[i][a] = '0;
                        kn_m[i][a]  = 4'hF;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        if (started) begin
            for (int i = 0; i < N; i++) begin
                chk("busy", i, 32'(busy_w[i]), 32'(rst || clr_left[i] > 0));
                chk("rd_valid", i, 32'(rd_valid_w[i]), 32'(ev[i]));
                if (ek[i]) chk("rd_data", i, rd_data_w[i], ed[i]);
            end
        end
        if (collect) begin
            for (int i = 0; i < N; i++) begin
                if (rd_valid_w[i] === 1'b1 && col_n[i] < 16) begin
                    col_d[i][col_n[i]] = rd_data_w[i];
                    if (col_n[i] == 0) col_first[i] = cyc;
                    col_last[i] = cyc;
                    col_n[i]++;
                end
            end
        end
    endtask

    task automatic drive(input bit we, input logic [5:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input bit re, input logic [5:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_rst(input bit v);
        rst = v;
        #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_w[0] === 1'b1 && cnt < 200) begin
            cycle();
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[i][a] = '0;
                kn_m[i][a]  = 4'h0;
            end
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle();

        // Clear sweep length after reset release.
        set_rst(0);
        count_busy(cnt);
        chk("sweep_len", 0, cnt, 64);
        chk("noclr_busy", 2, 32'(busy_w[2]), 0);

        // Back-to-back readback of every address after the sweep.
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 1, 6'(a));
            cycle();
        end
        idle(3);

        // Full then partial byte-enabled write.
        drive(1, 5, 32'hDEADBEEF, 4'b1111, 0, 0); cycle();
        drive(1, 5, 32'h11223344, 4'b0101, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 5); cycle();
        idle(3);
        for (int i = 0; i < N; i++) chk("byte_merge", i, rd_data_w[i], 32'hDE22BE44);

        // Same-address read during write.
        drive(1, 9, 32'hAAAAAAAA, 4'b1111, 0, 0); cycle();
        drive(1, 9, 32'h55555555, 4'b1111, 1, 9); cycle();
        idle(3);
        chk("rdw_old", 0, rd_data_w[0], 32'hAAAAAAAA);
        chk("rdw_new", 1, rd_data_w[1], 32'h55555555);
        chk("rdw_old", 2, rd_data_w[2], 32'hAAAAAAAA);

        // Back-to-back reads of addresses 0..7 holding their own index.
        for (int a = 0; a < 8; a++) begin
            drive(1, 6'(a), 32'(a), 4'b1111, 0, 0);
            cycle();
        end
        for (int i = 0; i < N; i++) col_n[i] = 0;
        collect = 1;
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 0, 1, 6'(a));
            cycle();
        end
        idle(3);
        collect = 0;
        for (int i = 0; i < N; i++) begin
            chk("b2b_count", i, col_n[i], 8);
            chk("b2b_span", i, col_last[i] - col_first[i], 7);
            for (int k = 0; k < 8; k++) chk("b2b_data", i, col_d[i][k], 32'(k));
        end

        // Reset during the sweep restarts it; writes while busy are dropped.
        set_rst(1);
        cycle();
        set_rst(0);
        for (int k = 0; k < 30; k++) begin
            drive(1, 12, 32'h12345678, 4'b1111, 1, 12);
            cycle();
        end
        drive(1, 13, 32'h87654321, 4'b1111, 1, 13);
        set_rst(1);
        cycle();
        set_rst(0);
        count_busy(cnt);
        chk("resweep_len", 0, cnt, 64);
        drive(0, 0, 0, 0, 1, 12); cycle();
        idle(3);
        chk("busy_wr_drop12", 0, rd_data_w[0], 32'h0);
        chk("busy_wr_drop12", 1, rd_data_w[1], 32'h0);
        drive(0, 0, 0, 0, 1, 13); cycle();
        idle(3);
        chk("busy_wr_drop13", 0, rd_data_w[0], 32'h0);
        chk("busy_wr_drop13", 1, rd_data_w[1], 32'h0);

        // Top address write/read.
        drive(1, 63, 32'hCAFEF00D, 4'b1111, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 63); cycle();
        idle(3);
        chk("top_addr", 0, rd_data_w[0], 32'hCAFEF00D);
        chk("top_addr", 2, rd_data_w[2], 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
